// File: rtl/mult_div_unit.sv
// Radix-2 iterative signed multiply/divide engine feeding the HI/LO registers.
// Define MULTDIV_UNSIGNED_EN to add the is_unsigned port (multu/divu semantics).
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    // state | meaning
    // IDLE  | waiting for start_mult / start_div
    // MULT  | shift-add iterations, then write product
    // DIV   | restoring-division iterations on magnitudes
    // FIX   | apply quotient/remainder signs, write result
    // DZERO | divisor was zero, report it next cycle
    // DONE  | result pulse cycle, starts ignored
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DZERO, DONE} stateType;

    stateType             state, stateNext;
    logic [CW-1:0]        cnt, cntNext;
    logic [2*WIDTH-1:0]   prod, prodNext;
    logic [WIDTH-1:0]     operand, operandNext;
    logic [WIDTH-1:0]     rem, remNext;
    logic [WIDTH-1:0]     quot, quotNext;
    logic                 negResult, negResultNext;
    logic                 negRem, negRemNext;
    logic [WIDTH-1:0]     hiNext, loNext;
    logic                 busyNext, doneNext, divZeroNext;

    logic                 unsignedOp;
    logic                 aNeg, bNeg;
    logic [WIDTH-1:0]     aMag, bMag;
    logic [WIDTH:0]       partialSum;
    logic [2*WIDTH-1:0]   prodStep, prodFinal;
    logic [WIDTH:0]       shifted, divisorExt;
    logic                 divGe;
    logic [WIDTH-1:0]     remStep, quotStep;
    logic [WIDTH-1:0]     quotFinal, remFinal;

`ifdef MULTDIV_UNSIGNED_EN
    assign unsignedOp = is_unsigned;
`else
    assign unsignedOp = 1'b0;
`endif

    assign aNeg = ~unsignedOp & a[WIDTH-1];
    assign bNeg = ~unsignedOp & b[WIDTH-1];
    assign aMag = aNeg ? -a : a;
    assign bMag = bNeg ? -b : b;

    // Multiply step: conditionally add multiplicand to the upper half, then shift right with carry.
    assign partialSum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, operand} : '0);
    assign prodStep   = {partialSum, prod[WIDTH-1:1]};
    assign prodFinal  = negResult ? -prod : prod;

    // Divide step: the partial remainder stays below the divisor, so W bits hold it between steps.
    assign shifted    = {rem, quot[WIDTH-1]};
    assign divisorExt = {1'b0, operand};
    assign divGe      = shifted >= divisorExt;
    assign remStep    = divGe ? WIDTH'(shifted - divisorExt) : shifted[WIDTH-1:0];
    assign quotStep   = {quot[WIDTH-2:0], divGe};
    assign quotFinal  = negResult ? -quot : quot;
    assign remFinal   = negRem ? -rem : rem;

    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        prodNext      = prod;
        operandNext   = operand;
        remNext       = rem;
        quotNext      = quot;
        negResultNext = negResult;
        negRemNext    = negRem;
        hiNext        = hi;
        loNext        = lo;
        busyNext      = busy;
        doneNext      = 1'b0;
        divZeroNext   = 1'b0;

        case (state)
            IDLE: begin
                if (start_mult) begin
                    stateNext     = MULT;
                    cntNext       = CW'(WIDTH);
                    prodNext      = {{WIDTH{1'b0}}, bMag};
                    operandNext   = aMag;
                    negResultNext = aNeg ^ bNeg;
                    negRemNext    = 1'b0;
                    busyNext      = 1'b1;
                end else if (start_div) begin
                    stateNext     = (b == '0) ? DZERO : DIV;
                    cntNext       = CW'(WIDTH);
                    remNext       = '0;
                    quotNext      = aMag;
                    operandNext   = bMag;
                    negResultNext = aNeg ^ bNeg;
                    negRemNext    = aNeg;
                    busyNext      = 1'b1;
                end
            end
            MULT: begin
                if (cnt != '0) begin
                    prodNext = prodStep;
                    cntNext  = cnt - CW'(1);
                end else begin
                    hiNext    = prodFinal[2*WIDTH-1:WIDTH];
                    loNext    = prodFinal[WIDTH-1:0];
                    doneNext  = 1'b1;
                    busyNext  = 1'b0;
                    stateNext = DONE;
                end
            end
            DIV: begin
                if (cnt != '0) begin
                    remNext  = remStep;
                    quotNext = quotStep;
                    cntNext  = cnt - CW'(1);
                end else begin
                    stateNext = FIX;
                end
            end
            FIX: begin
                hiNext    = remFinal;
                loNext    = quotFinal;
                doneNext  = 1'b1;
                busyNext  = 1'b0;
                stateNext = DONE;
            end
            DZERO: begin
                doneNext    = 1'b1;
                divZeroNext = 1'b1;
                busyNext    = 1'b0;
                stateNext   = IDLE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            prod      <= '0;
            operand   <= '0;
            rem       <= '0;
            quot      <= '0;
            negResult <= 1'b0;
            negRem    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            prod      <= prodNext;
            operand   <= operandNext;
            rem       <= remNext;
            quot      <= quotNext;
            negResult <= negResultNext;
            negRem    <= negRemNext;
            hi        <= hiNext;
            lo        <= loNext;
            busy      <= busyNext;
            done      <= doneNext;
            div_zero  <= divZeroNext;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model plus literal result checks.
// Covers the MULTDIV_UNSIGNED_EN build when that macro is defined.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;
`ifdef MULTDIV_UNSIGNED_EN
    logic        isUnsigned = 1'b0;
`endif

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
`ifdef MULTDIV_UNSIGNED_EN
        .is_unsigned(isUnsigned),
`endif
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    int edgeCount = 0;
    always @(posedge clk) edgeCount <= edgeCount + 1;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          opActive = 1'b0;
    int          t0Edge = 0;
    int          opLat = 0;
    logic [31:0] pendHi = '0, pendLo = '0;
    bit          pendDz = 1'b0;
    logic [31:0] expHi = '0, expLo = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Result and latency from plain arithmetic.
    function automatic void calc(input bit isMul, input bit uns, input logic [31:0] x,
                                 input logic [31:0] y, output logic [31:0] h,
                                 output logic [31:0] l, output bit dz, output int lat);
        logic signed [63:0] sx, sy, q, r;
        logic [63:0] p;
        dz = 1'b0;
        if (uns) begin
            sx = {32'b0, x};
            sy = {32'b0, y};
        end else begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
        end
        if (isMul) begin
            p   = sx * sy;
            h   = p[63:32];
            l   = p[31:0];
            lat = 33;
        end else if (y == 32'd0) begin
            h   = expHi;
            l   = expLo;
            dz  = 1'b1;
            lat = 1;
        end else begin
            q   = sx / sy;
            r   = sx % sy;
            h   = r[31:0];
            l   = q[31:0];
            lat = 34;
        end
    endfunction

    initial begin : compareProc
        bit eb, ed, ez;
        int k;
        forever begin
            @(negedge clk);
            if (reset) begin
                eb = 1'b0; ed = 1'b0; ez = 1'b0;
                if (opActive) begin
                    k = edgeCount - t0Edge;
                    if (k < opLat) eb = 1'b1;
                    else if (k == opLat) begin
                        ed = 1'b1;
                        ez = pendDz;
                        if (!pendDz) begin
                            expHi = pendHi;
                            expLo = pendLo;
                        end
                    end else opActive = 1'b0;
                end
                check("cyc_busy", {63'b0, busy}, {63'b0, eb});
                check("cyc_done", {63'b0, done}, {63'b0, ed});
                check("cyc_divzero", {63'b0, div_zero}, {63'b0, ez});
                check("cyc_hi", {32'b0, hi}, {32'b0, expHi});
                check("cyc_lo", {32'b0, lo}, {32'b0, expLo});
            end
        end
    end

    task automatic startOp(input bit sm, input bit sd, input bit uns,
                           input logic [31:0] x, input logic [31:0] y);
        logic [31:0] h, l;
        bit dz;
        int lat;
        @(negedge clk);
        start_mult = sm;
        start_div  = sd;
        a = x;
        b = y;
`ifdef MULTDIV_UNSIGNED_EN
        isUnsigned = uns;
`endif
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a = 32'hDEADBEEF;
        b = 32'hDEADBEEF;
`ifdef MULTDIV_UNSIGNED_EN
        isUnsigned = ~uns;
`endif
        calc(sm, uns, x, y, h, l, dz, lat);
        pendHi   = h;
        pendLo   = l;
        pendDz   = dz;
        opLat    = lat;
        t0Edge   = edgeCount;
        opActive = 1'b1;
    endtask

    task automatic finishOp(input string name, input int latLit, input logic [31:0] hiLit,
                            input logic [31:0] loLit, input bit dzLit);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=no_done expected=done", name);
        end else begin
            check({name, "_lat"}, 64'(edgeCount - t0Edge), 64'(latLit));
            check({name, "_hi"}, {32'b0, hi}, {32'b0, hiLit});
            check({name, "_lo"}, {32'b0, lo}, {32'b0, loLit});
            check({name, "_dz"}, {63'b0, div_zero}, {63'b0, dzLit});
        end
    endtask

    task automatic runOp(input string name, input bit sm, input bit sd, input bit uns,
                         input logic [31:0] x, input logic [31:0] y, input int latLit,
                         input logic [31:0] hiLit, input logic [31:0] loLit, input bit dzLit);
        startOp(sm, sd, uns, x, y);
        finishOp(name, latLit, hiLit, loLit, dzLit);
    endtask

    initial begin : mainProc
        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_dz", {63'b0, div_zero}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        reset = 1'b1;

        runOp("mul_7_m3", 1, 0, 0, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        runOp("mul_max", 1, 0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 33, 32'h3FFFFFFF, 32'h00000001, 0);
        runOp("div_7_m2", 0, 1, 0, 32'd7, 32'hFFFFFFFE, 34, 32'h00000001, 32'hFFFFFFFD, 0);
        runOp("div_m7_2", 0, 1, 0, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        runOp("div_zero", 0, 1, 0, 32'h12345678, 32'd0, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1);
        runOp("div_ovf", 0, 1, 0, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, 0);
        runOp("both_start", 1, 1, 0, 32'd3, 32'd5, 33, 32'h00000000, 32'd15, 0);
        runOp("mul_m1_m1", 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000000, 32'd1, 0);
        runOp("mul_min_min", 1, 0, 0, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h00000000, 0);
        runOp("div_m100_m7", 0, 1, 0, 32'hFFFFFF9C, 32'hFFFFFFF9, 34, 32'hFFFFFFFE, 32'd14, 0);
        runOp("div_small", 0, 1, 0, 32'd3, 32'd10, 34, 32'd3, 32'd0, 0);

        // starts while busy and while done must be ignored
        startOp(1, 0, 0, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        start_div = 1'b1;
        a = 32'd100;
        b = 32'd0;
        @(negedge clk);
        start_div = 1'b0;
        finishOp("busy_ignore", 33, 32'd0, 32'd42, 0);
        start_mult = 1'b1;
        a = 32'd2;
        b = 32'd2;
        @(posedge clk);
        #1 start_mult = 1'b0;
        repeat (3) @(negedge clk);
        check("done_ignore_busy", {63'b0, busy}, 64'd0);
        check("done_ignore_lo", {32'b0, lo}, 64'd42);

        // asynchronous reset in the middle of a multiply
        startOp(1, 0, 0, 32'h11111111, 32'h22222222);
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        opActive = 1'b0;
        expHi = '0;
        expLo = '0;
        #1;
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_done", {63'b0, done}, 64'd0);
        check("midrst_hi", {32'b0, hi}, 64'd0);
        check("midrst_lo", {32'b0, lo}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        runOp("post_rst_div", 0, 1, 0, 32'd100, 32'd7, 34, 32'd2, 32'd14, 0);

`ifdef MULTDIV_UNSIGNED_EN
        runOp("divu", 0, 1, 1, 32'hFFFFFFFF, 32'd2, 34, 32'h00000001, 32'h7FFFFFFF, 0);
        runOp("multu", 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, 0);
        runOp("divu_zero", 0, 1, 1, 32'd5, 32'd0, 1, 32'hFFFFFFFE, 32'h00000001, 1);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
